serial_subtractor: RTL and testbench

// - Bit-serial, LSB-first two's-complement subtractor: diff = a - b over WIDTH-bit words.
// - Inverse datapath of the clocked full-adder chain, built from the same stages:

---
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 tb/tb_serial_subtractor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first two's-complement subtractor (diff = a - b) with a two-stage
// pipeline. Optional signed-overflow output is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_first,
    input  logic a,
    input  logic b,
    output logic diff,
    output logic out_valid,
    output logic out_first,
    output logic out_last,
    output logic borrow_out,
    output logic abort,
    output logic ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic          r_s1_valid;
    logic          r_s1_a;
    logic          r_s1_b;
    logic          r_s1_first;
    logic          r_s1_last;
    logic          r_s1_abort;
    logic          r_borrow;
    logic          r_diff;
    logic          r_out_valid;
    logic          r_out_first;
    logic          r_out_last;
    logic          r_borrow_out;
    logic          r_abort;

    logic w_mid_word;
    logic w_accept;
    logic w_last;
    logic w_abort;
    logic w_bin;
    logic w_diff;
    logic w_bnext;

    // Accept decode: bits outside a word (counter 0, no in_first) are dropped
    always_comb begin
        w_mid_word = (r_cnt != '0);
        w_accept   = in_valid & (in_first | w_mid_word);
        w_last     = ~in_first & (r_cnt == LAST_IDX);
        w_abort    = in_first & w_mid_word;
    end

    // Stage 1: bit counter and input register with first/last/abort tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_a     <= 1'b0;
            r_s1_b     <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_abort <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a     <= a;
                r_s1_b     <= b;
                r_s1_first <= in_first;
                r_s1_last  <= w_last;
                r_s1_abort <= w_abort;
                if (in_first) begin
                    r_cnt <= CW'(1);
                end else if (r_cnt == LAST_IDX) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Stage 2 combinational borrow logic; a word start never sees a stale borrow
    always_comb begin
        w_bin   = r_s1_first ? 1'b0 : r_borrow;
        w_diff  = r_s1_a ^ r_s1_b ^ w_bin;
        w_bnext = (~r_s1_a & r_s1_b) | (~(r_s1_a ^ r_s1_b) & w_bin);
    end

    // Stage 2: registered outputs and borrow state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_borrow     <= 1'b0;
            r_diff       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_first  <= 1'b0;
            r_out_last   <= 1'b0;
            r_borrow_out <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_first <= r_s1_valid & r_s1_first;
            r_out_last  <= r_s1_valid & r_s1_last;
            r_abort     <= r_s1_valid & r_s1_abort;
            if (r_s1_valid) begin
                r_diff   <= w_diff;
                r_borrow <= r_s1_last ? 1'b0 : w_bnext;
                if (r_s1_last) begin
                    r_borrow_out <= w_bnext;
                end else begin
                    r_borrow_out <= r_borrow_out;
                end
            end else begin
                r_diff   <= r_diff;
                r_borrow <= r_borrow;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // Signed overflow: borrow into the MSB differs from borrow out of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_s1_valid && r_s1_last) begin
            r_ovf <= w_bin ^ w_bnext;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign diff       = r_diff;
    assign out_valid  = r_out_valid;
    assign out_first  = r_out_first;
    assign out_last   = r_out_last;
    assign borrow_out = r_borrow_out;
    assign abort      = r_abort;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: table of back-to-back words plus
// hand-written latency, abort and mid-word reset sequences.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic in_first = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic diff, out_valid, out_first, out_last, borrow_out, abort, ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
        .a(a), .b(b), .diff(diff), .out_valid(out_valid), .out_first(out_first),
        .out_last(out_last), .borrow_out(borrow_out), .abort(abort), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           span;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] gaps;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    res_t resq[$];
    res_t expq[$];

    logic [W-1:0] cap = '0;
    int cap_idx = 0;
    int first_cyc = 0;
    int n_valid = 0, n_first = 0, n_last = 0, n_abort = 0, n_abort_first = 0;
    logic abort_borrow = 1'b0;
    logic abort_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: assembles words and records tag/timing events
    always @(negedge clk) begin
        if (abort) begin
            n_abort++;
            if (out_valid && out_first) n_abort_first++;
            abort_borrow = borrow_out;
            abort_ovf = ovf;
        end
        if (out_valid) begin
            res_t r;
            n_valid++;
            if (out_first) begin
                cap_idx = 0;
                first_cyc = cyc;
                n_first++;
            end
            if (cap_idx < W) cap[cap_idx] = diff;
            cap_idx++;
            if (out_last) begin
                n_last++;
                r.d = cap;
                r.bo = borrow_out;
                r.ov = ovf;
                r.span = cyc - first_cyc;
                resq.push_back(r);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic f, input logic va, input logic vb);
        @(negedge clk);
        in_valid = 1'b1;
        in_first = f;
        a = va;
        b = vb;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_first = 1'b0;
        end
    endtask

    task automatic send_word(input logic [W-1:0] va, input logic [W-1:0] vb,
                             input logic [W-1:0] gaps, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit(i == 0, va[i], vb[i]);
            if (gaps[i]) idle(1);
        end
    endtask

    task automatic expect_word(input logic [W-1:0] d, input logic bo, input logic ov, input int span);
        res_t r;
        r.d = d;
        r.bo = bo;
`ifdef SERIAL_SUB_OVF_EN
        r.ov = ov;
`else
        r.ov = 1'b0;
`endif
        r.span = span;
        expq.push_back(r);
    endtask

    task automatic drain_compare(input string tag);
        int n;
        idle(4);
        check($sformatf("%s_nwords", tag), resq.size(), expq.size());
        n = (resq.size() < expq.size()) ? resq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_diff[%0d]", tag, i), resq[i].d, expq[i].d);
            check($sformatf("%s_borrow[%0d]", tag, i), resq[i].bo, expq[i].bo);
            check($sformatf("%s_ovf[%0d]", tag, i), resq[i].ov, expq[i].ov);
            check($sformatf("%s_span[%0d]", tag, i), resq[i].span, expq[i].span);
        end
        resq.delete();
        expq.delete();
    endtask

    vec_t vt[7];

    initial begin
        int v0, a0, af0, l0;
        vt[0] = '{8'h05, 8'h03, 8'h00, 8'h02, 1'b0, 1'b0};
        vt[1] = '{8'h03, 8'h05, 8'h00, 8'hFE, 1'b1, 1'b0};
        vt[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vt[3] = '{8'hAA, 8'h55, 8'h24, 8'h55, 1'b0, 1'b1};
        vt[4] = '{8'h80, 8'h01, 8'h00, 8'h7F, 1'b0, 1'b1};
        vt[5] = '{8'h7F, 8'h01, 8'h00, 8'h7E, 1'b0, 1'b0};
        vt[6] = '{8'h01, 8'h80, 8'h00, 8'h81, 1'b1, 1'b1};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {diff, out_valid, out_first, out_last, borrow_out, abort, ovf}, 32'd0);
        rst_n = 1'b1;

        // Latency: bit 0 accepted, then two bubbles, rest of 0x01-0x01
        send_bit(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        check("latency_1edge_valid", out_valid, 1'b0);
        @(negedge clk);
        check("latency_2edge_valid_first", {out_valid, out_first}, 2'b11);
        for (int i = 1; i < W; i++) send_bit(1'b0, 1'b0, 1'b0);
        expect_word(8'h00, 1'b0, 1'b0, W + 1);
        drain_compare("lat");

        // Table: back-to-back words, bubbles where gaps marks them
        for (int i = 0; i < 7; i++) begin
            send_word(vt[i].a, vt[i].b, vt[i].gaps, W);
            expect_word(vt[i].d, vt[i].bo, vt[i].ov, (W - 1) + $countones(vt[i].gaps));
        end
        drain_compare("tbl");

        // Abort: 4 bits of a borrowing partial word cut short by a new word
        v0 = n_valid; a0 = n_abort; af0 = n_abort_first; l0 = n_last;
        send_word(8'h05, 8'h03, 8'h00, W);
        send_word(8'h00, 8'hFF, 8'h00, 4);
        send_word(8'h0F, 8'h01, 8'h00, W);
        expect_word(8'h02, 1'b0, 1'b0, W - 1);
        expect_word(8'h0E, 1'b0, 1'b0, W - 1);
        drain_compare("abort");
        check("abort_pulses", n_abort - a0, 32'd1);
        check("abort_with_first", n_abort_first - af0, 32'd1);
        check("abort_out_lasts", n_last - l0, 32'd2);
        check("abort_valid_bits", n_valid - v0, 32'd20);
        check("abort_borrow_held", abort_borrow, 1'b0);
        check("abort_ovf_held", abort_ovf, 1'b0);

        // Reset mid-word after a borrowing word
        send_word(8'h00, 8'h01, 8'h00, W);
        expect_word(8'hFF, 1'b1, 1'b0, W - 1);
        drain_compare("pre_rst");
        check("borrow_before_reset", borrow_out, 1'b1);
        send_word(8'h33, 8'h11, 8'h00, 3);
        send_bit(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("midword_reset_outputs",
                 {diff, out_valid, out_first, out_last, borrow_out, abort, ovf}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        v0 = n_valid;
        for (int i = 0; i < W; i++) send_bit(1'b0, 1'b1, 1'b0);
        idle(4);
        check("no_output_without_first", n_valid - v0, 32'd0);
        send_word(8'h10, 8'h01, 8'h00, W);
        expect_word(8'h0F, 1'b0, 1'b0, W - 1);
        drain_compare("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
